wb_mem_tester: RTL
==================

Name: wb_mem_tester

Overview:
Synthesizable Wishbone B4 registered-feedback master that fills a memory region with a generated pattern using incrementing bursts, then reads it back and compares it. It sits in front of wb_hyper's data slave, or any Wishbone memory, for on-hardware HyperRAM bring-up and soak testing. It replaces the simulation-only write/read-compare sequence with a hardware engine that is parametrised in data width, burst length, pattern mode and timeout.

Parameters:
AW, 32, Wishbone address width (byte address)
DW, 32, data width; legal values 8, 16, 32
BURST_LEN, 4, maximum beats per burst, 1..256
TIMEOUT, 1024, cycles without ack before a beat is aborted
ERR_W, 16, error counter width

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle pulse that starts a test; ignored while busy_o=1
mode_i  in  2  pattern select: 0 address-as-data, 1 LFSR, 2 walking-one, 3 fixed
base_adr_i  in  AW  start byte address; must be DW/8 aligned
len_i  in  24  region length in words
seed_i  in  32  LFSR seed (mode 1) or fixed word (mode 3)
busy_o  out  1  test in progress
done_o  out  1  one-cycle pulse at test end
pass_o  out  1  valid from done_o until the next start_i
err_cnt_o  out  ERR_W  saturating count of mismatched words
first_err_adr_o  out  AW  byte address of the first mismatch
bus_err_o  out  1  test aborted by wb_err_i
timeout_o  out  1  test aborted by timeout
wb_adr_o  out  AW  byte address
wb_dat_o  out  DW  write data
wb_sel_o  out  DW/8  byte selects, always all ones
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type identifier
wb_bte_o  out  2  burst type extension, always 2'b00 (linear)
wb_dat_i  in  DW  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error

Behaviour:
- Reset: state IDLE. All outputs 0, except wb_sel_o = all ones. Reset takes effect at the next edge, including mid-burst: cyc/stb go low that edge and no done_o pulse is produced.
- States: IDLE -> WR_BURST -> WR_GAP -> (WR_BURST | RD_BURST) ... RD_BURST -> RD_GAP -> (RD_BURST | FIN) -> IDLE.
- start_i in IDLE latches mode, base, len and seed; clears err_cnt, first_err_adr, bus_err, timeout and pass; sets busy_o. If len_i=0, the block goes to FIN directly (pass_o=1, no bus activity).
- Burst size is min(BURST_LEN, remaining words).
  - size>1: cti=3'b010 on each beat, 3'b111 on the last beat.
  - size=1: cti=3'b000.
- cyc and stb are asserted together on the first beat and held through wait states. On each ack: address += DW/8, the pattern generator steps, and the remaining count decrements. cyc and stb drop the cycle after the last ack.
- GAP states: exactly one idle cycle with cyc=0 between bursts, and between the write and read phases.
- Pattern generation:
  - mode 0: data = wb_adr_o[DW-1:0].
  - mode 1: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, stepped per beat, output low DW bits. A seed of 0 is replaced by 32'h1.
  - mode 2: 1 << (beat index mod DW).
  - mode 3: seed_i[DW-1:0].
  - The generator and address restart from the latched values at the start of the read phase.
- Compare: on a read ack, a mismatch occurs if wb_dat_i != expected. err_cnt increments and saturates at all ones. first_err_adr captures the first mismatch only.
- wb_err_i during any beat: drop cyc next edge, set bus_err_o, go to FIN with pass_o=0.
- Timeout counter resets on each ack and on each new burst. Reaching TIMEOUT sets timeout_o, drops cyc and goes to FIN with pass_o=0.
- Simultaneous ack and err: err wins, and the beat is not counted.
- FIN: done_o pulses for one cycle; pass_o = (err_cnt==0 && !bus_err && !timeout); busy_o=0; return to IDLE.
- Address wrap past 2^AW wraps modulo 2^AW, with no error.

Decomposition:
- Shared package wb_mem_tester_pkg: state encoding, CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111), mode constants, LFSR polynomial constant.
- One sub-module: wb_pattern_gen (mode, seed, address, load, step -> DW data). Instantiated once and reloaded for the read phase.

Test Plan:
- mode 0, base 0, len 8, BURST_LEN 4, zero-wait slave model -> two write bursts with cti 010,010,010,111, then two read bursts; done_o pulses; pass_o=1; err_cnt_o=0.
- mode 1, seed 32'hACE1, len 6, BURST_LEN 4, slave with 0-3 random wait states -> bursts of 4 then 2; exact LFSR sequence written and read back; pass_o=1.
- mode 3, seed 32'h12345678, len 4; slave corrupts the read at byte address 8 -> err_cnt_o=1, first_err_adr_o=32'h8, pass_o=0.
- len 1 -> a single classic write and a single classic read with cti 000; len 0 -> done_o 1 cycle after start, no cyc, pass_o=1.
- Slave asserts wb_err_i on write beat 2 (or never acks, with TIMEOUT=16) -> cyc low next edge; bus_err_o=1 (or timeout_o=1 after 16 cycles); pass_o=0.
- wb_rst_i asserted mid read burst -> cyc, stb and busy low at the next edge, no done_o; a new start_i then runs a full test to pass_o=1.

Source files
------------

// File: rtl/wb_mem_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_tester_pkg
//  Description : Shared types and constants for the Wishbone memory tester:
//                FSM encoding, cycle-type codes, pattern modes and the LFSR.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_WR_GAP   = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_RD_GAP   = 3'd4,
    ST_FIN      = 3'd5
  } state_e;

  localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] c_CTI_INCR    = 3'b010;
  localparam logic [2:0] c_CTI_EOB     = 3'b111;

  localparam logic [1:0] c_MODE_ADDR  = 2'd0;
  localparam logic [1:0] c_MODE_LFSR  = 2'd1;
  localparam logic [1:0] c_MODE_WALK  = 2'd2;
  localparam logic [1:0] c_MODE_FIXED = 2'd3;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [31:0] c_LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? c_LFSR_POLY : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_tester_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pattern_gen
//  Description : Test pattern source. Reloaded from seed at the start of each
//                phase, stepped once per accepted beat.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_pattern_gen
  import wb_mem_tester_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    mode_i,
  input  logic [31:0]   seed_i,
  input  logic [DW-1:0] adr_i,
  input  logic          load_i,
  input  logic          step_i,
  output logic [DW-1:0] data_o
);

  localparam int IW = $clog2(DW);

  logic [31:0]   lfsr_q;
  logic [IW-1:0] idx_q;

  // LFSR state and walking-one beat index; load has priority over step
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 32'h1;
      idx_q  <= '0;
    end else if (load_i) begin
      lfsr_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
      idx_q  <= '0;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
      idx_q  <= idx_q + 1'b1;   // DW is a power of two, so this wraps mod DW
    end
  end

  // Current pattern word for the selected mode
  always_comb begin
    data_o = '0;
    case (mode_i)
      c_MODE_ADDR:  data_o = adr_i;
      c_MODE_LFSR:  data_o = lfsr_q[DW-1:0];
      c_MODE_WALK:  data_o = DW'(1) << idx_q;
      c_MODE_FIXED: data_o = seed_i[DW-1:0];
      default:      data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_mem_tester.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_tester
//  Description : Wishbone B4 registered-feedback master that fills a region
//                with a pattern in incrementing bursts, reads it back and
//                counts mismatches.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 1024,
  parameter int ERR_W     = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [AW-1:0]     base_adr_i,
  input  logic [23:0]       len_i,
  input  logic [31:0]       seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [AW-1:0]     first_err_adr_o,
  output logic              bus_err_o,
  output logic              timeout_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int            BW     = $clog2(BURST_LEN + 1);
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] c_STEP = AW'(DW / 8);

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [AW-1:0]     base_q, adr_q, first_err_adr_q;
  logic [23:0]       len_q, rem_q;
  logic [31:0]       seed_q;
  logic [BW-1:0]     burst_rem_q;
  logic              burst_one_q;
  logic [TW-1:0]     tmo_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              bus_err_q, timeout_q, pass_vld_q;

  logic              w_in_burst, w_beat_ok, w_tmo_hit;
  logic [23:0]       w_phase_rem;
  logic [BW-1:0]     w_burst_size;
  logic              w_gen_load, w_gen_step;
  logic [31:0]       w_gen_seed;
  logic [DW-1:0]     w_pat;

  assign w_in_burst = (state_q == ST_WR_BURST) || (state_q == ST_RD_BURST);
  // err beats ack: an errored beat is never counted
  assign w_beat_ok  = wb_ack_i && !wb_err_i;
  assign w_tmo_hit  = !wb_ack_i && !wb_err_i && (tmo_q == TW'(TIMEOUT - 1));

  // Words left for the burst about to be launched (new test, next burst, or read phase)
  always_comb begin
    w_phase_rem = rem_q;
    if (state_q == ST_IDLE)
      w_phase_rem = len_i;
    else if (state_q == ST_WR_GAP && rem_q == 24'd0)
      w_phase_rem = len_q;
  end

  assign w_burst_size = (w_phase_rem >= 24'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(w_phase_rem);

  // Generator restarts at test start and again when the read phase begins
  assign w_gen_load = ((state_q == ST_IDLE) && start_i) ||
                      ((state_q == ST_WR_GAP) && (rem_q == 24'd0));
  assign w_gen_step = w_in_burst && w_beat_ok;
  assign w_gen_seed = (state_q == ST_IDLE) ? seed_i : seed_q;

  wb_pattern_gen #(.DW(DW)) u_gen (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .mode_i (mode_q),
    .seed_i (w_gen_seed),
    .adr_i  (adr_q[DW-1:0]),
    .load_i (w_gen_load),
    .step_i (w_gen_step),
    .data_o (w_pat)
  );

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and bus/status outputs decoded from the current state
  always_comb begin
    state_d  = state_q;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_cti_o = c_CTI_CLASSIC;
    done_o   = 1'b0;
    busy_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (len_i == 24'd0) ? ST_FIN : ST_WR_BURST;
      end
      ST_WR_BURST, ST_RD_BURST: begin
        busy_o   = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = (state_q == ST_WR_BURST);
        if (burst_one_q)                  wb_cti_o = c_CTI_CLASSIC;
        else if (burst_rem_q == BW'(1))   wb_cti_o = c_CTI_EOB;
        else                              wb_cti_o = c_CTI_INCR;
        if (wb_err_i)
          state_d = ST_FIN;
        else if (wb_ack_i && burst_rem_q == BW'(1))
          state_d = (state_q == ST_WR_BURST) ? ST_WR_GAP : ST_RD_GAP;
        else if (w_tmo_hit)
          state_d = ST_FIN;
      end
      ST_WR_GAP: begin
        busy_o  = 1'b1;
        state_d = (rem_q != 24'd0) ? ST_WR_BURST : ST_RD_BURST;
      end
      ST_RD_GAP: begin
        busy_o  = 1'b1;
        state_d = (rem_q != 24'd0) ? ST_RD_BURST : ST_FIN;
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: address, counters, compare results and sticky status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mode_q          <= 2'd0;
      base_q          <= '0;
      adr_q           <= '0;
      len_q           <= 24'd0;
      rem_q           <= 24'd0;
      seed_q          <= 32'd0;
      burst_rem_q     <= '0;
      burst_one_q     <= 1'b0;
      tmo_q           <= '0;
      err_cnt_q       <= '0;
      first_err_adr_q <= '0;
      bus_err_q       <= 1'b0;
      timeout_q       <= 1'b0;
      pass_vld_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q          <= mode_i;
            base_q          <= base_adr_i;
            adr_q           <= base_adr_i;
            len_q           <= len_i;
            rem_q           <= len_i;
            seed_q          <= seed_i;
            burst_rem_q     <= w_burst_size;
            burst_one_q     <= (w_burst_size == BW'(1));
            tmo_q           <= '0;
            err_cnt_q       <= '0;
            first_err_adr_q <= '0;
            bus_err_q       <= 1'b0;
            timeout_q       <= 1'b0;
            pass_vld_q      <= 1'b0;
          end
        end
        ST_WR_BURST, ST_RD_BURST: begin
          if (wb_err_i) begin
            bus_err_q <= 1'b1;
          end else if (wb_ack_i) begin
            adr_q       <= adr_q + c_STEP;
            rem_q       <= rem_q - 1'b1;
            burst_rem_q <= burst_rem_q - 1'b1;
            tmo_q       <= '0;
            if (state_q == ST_RD_BURST && wb_dat_i != w_pat) begin
              if (err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 1'b1;
              if (err_cnt_q == '0)  first_err_adr_q <= adr_q;
            end
          end else if (w_tmo_hit) begin
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WR_GAP: begin
          tmo_q       <= '0;
          burst_rem_q <= w_burst_size;
          burst_one_q <= (w_burst_size == BW'(1));
          if (rem_q == 24'd0) begin
            adr_q <= base_q;
            rem_q <= len_q;
          end
        end
        ST_RD_GAP: begin
          tmo_q       <= '0;
          burst_rem_q <= w_burst_size;
          burst_one_q <= (w_burst_size == BW'(1));
        end
        ST_FIN: begin
          pass_vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pass_o          = (pass_vld_q || state_q == ST_FIN) && (err_cnt_q == '0) &&
                           !bus_err_q && !timeout_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_adr_o = first_err_adr_q;
  assign bus_err_o       = bus_err_q;
  assign timeout_o       = timeout_q;
  assign wb_adr_o        = adr_q;
  assign wb_dat_o        = (state_q == ST_WR_BURST) ? w_pat : '0;
  assign wb_sel_o        = '1;
  assign wb_bte_o        = 2'b00;

endmodule
`default_nettype wire
